// File: rtl/i2c_txn_arbiter_if.sv
// Bundles the requester-side and engine-side signals of the I2C transaction arbiter.
// The arbiter uses the master modport; the requesters/engine side uses the slave modport.
interface i2c_txn_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]         req_valid;
    logic [7*NREQ-1:0]       req_addr;
    logic [NREQ-1:0]         req_rw;
    logic [8*NREQ-1:0]       req_wdata;
    logic [NREQ-1:0]         rsp_done;
    logic [1:0]              rsp_status;
    logic [7:0]              rsp_rdata;
    logic                    busy;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic                    m_start;
    logic [6:0]              m_addr;
    logic                    m_rw;
    logic [7:0]              m_wdata;
    logic                    m_busy;
    logic                    m_done;
    logic                    m_nack;
    logic [7:0]              m_rdata;

    modport master (
        input  req_valid, req_addr, req_rw, req_wdata,
        input  m_busy, m_done, m_nack, m_rdata,
        output rsp_done, rsp_status, rsp_rdata, busy, grant_id,
        output m_start, m_addr, m_rw, m_wdata
    );

    modport slave (
        output req_valid, req_addr, req_rw, req_wdata,
        output m_busy, m_done, m_nack, m_rdata,
        input  rsp_done, rsp_status, rsp_rdata, busy, grant_id,
        input  m_start, m_addr, m_rw, m_wdata
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C engine among NREQ requesters,
// with NACK retry back-off and a per-attempt timeout watchdog.
module i2c_txn_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_RETRY = 2,
    parameter int RETRY_GAP = 16,
    parameter int TIMEOUT   = 4096
) (
    input logic               clk,
    input logic               reset,
    i2c_txn_arbiter_if.master bus
);
    localparam int IDW  = $clog2(NREQ);
    localparam int TMAX = (TIMEOUT > RETRY_GAP) ? TIMEOUT : RETRY_GAP;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int RW   = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   GAP_LAST     = TW'(RETRY_GAP - 1);
    localparam logic [RW-1:0]   RETRY_LIMIT  = RW'(MAX_RETRY);
    localparam logic [IDW-1:0]  LAST_ID      = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0     = NREQ'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [6:0]     addr_q, addr_d;
    logic           rw_q, rw_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [1:0]     status_q, status_d;
    logic [7:0]     rdata_q, rdata_d;

    logic           pick_vld_s;
    logic [IDW-1:0] pick_id_s;
    logic [IDW-1:0] scan_idx_s;
    logic [6:0]     req_addr_s  [NREQ];
    logic [7:0]     req_wdata_s [NREQ];

    // Unpack the flat per-requester payload buses into indexable arrays
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_addr_s[i]  = bus.req_addr[7*i +: 7];
            req_wdata_s[i] = bus.req_wdata[8*i +: 8];
        end
    end

    // Rotating-priority scan: first pending requester at or after rr_ptr
    always_comb begin
        pick_vld_s = 1'b0;
        pick_id_s  = '0;
        scan_idx_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx_s = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!pick_vld_s && bus.req_valid[scan_idx_s]) begin
                pick_vld_s = 1'b1;
                pick_id_s  = scan_idx_s;
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            retry_q  <= '0;
            timer_q  <= '0;
            addr_q   <= 7'h00;
            rw_q     <= 1'b0;
            wdata_q  <= 8'h00;
            status_q <= 2'b00;
            rdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state and datapath update; the timer is shared by the watchdog and the retry gap
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld_s) begin
                    grant_d = pick_id_s;
                    addr_d  = req_addr_s[pick_id_s];
                    rw_d    = bus.req_rw[pick_id_s];
                    wdata_d = req_wdata_s[pick_id_s];
                    retry_d = '0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (!bus.m_busy) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // m_done takes priority over a watchdog expiry in the same cycle
                if (bus.m_done && !bus.m_nack) begin
                    status_d = 2'b00;
                    rdata_d  = rw_q ? bus.m_rdata : 8'h00;
                    state_d  = S_RESP;
                end else if (bus.m_done && (retry_q < RETRY_LIMIT)) begin
                    retry_d = retry_q + RW'(1);
                    timer_d = '0;
                    state_d = S_GAP;
                end else if (bus.m_done) begin
                    status_d = 2'b01;
                    rdata_d  = 8'h00;
                    state_d  = S_RESP;
                end else if (timer_q == TIMEOUT_LAST) begin
                    status_d = 2'b10;
                    rdata_d  = 8'h00;
                    state_d  = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = S_ISSUE;
                end else begin
                    timer_d = timer_q + TW'(1);
                    state_d = S_GAP;
                end
            end
            S_RESP: begin
                rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + IDW'(1);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs; response fields are only driven during RESP
    always_comb begin
        bus.m_start    = 1'b0;
        bus.rsp_done   = '0;
        bus.rsp_status = 2'b00;
        bus.rsp_rdata  = 8'h00;
        bus.busy       = 1'b1;
        case (state_q)
            S_IDLE: begin
                bus.busy = 1'b0;
            end
            S_ISSUE: begin
                bus.m_start = !bus.m_busy;
            end
            S_RESP: begin
                bus.rsp_done   = ONE_HOT0 << grant_q;
                bus.rsp_status = status_q;
                bus.rsp_rdata  = rdata_q;
            end
            default: begin
                bus.busy = 1'b1;
            end
        endcase
    end

    assign bus.grant_id = grant_q;
    assign bus.m_addr   = addr_q;
    assign bus.m_rw     = rw_q;
    assign bus.m_wdata  = wdata_q;
endmodule
